i2c_slave_regs: RTL and testbench

I2C target (slave) with an internal 16 x 8-bit register file, sitting on the same SCL/SDA bus as the team's I2C master driver. It decodes the master's write sequence (START, device address + W, register address, data bytes) and read sequence (START, device address + R, data bytes). It ACKs matching transfers and auto-increments its register pointer. A local read port and a write strobe expose the register file to on-chip logic.

---
 rtl/i2c_slave_regs_if.sv | 33 +++
 rtl/i2c_slave_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regs_if.sv
// Clock line and local register-access signals of the I2C register target.
// The open-drain SDA net is a plain inout on the target, so it is not part of this bundle.
interface i2c_slave_regs_if #(
  parameter int PTR_W = 4
);
  logic             scl;
  logic [PTR_W-1:0] locAddr;
  logic [7:0]       locData;
  logic             wrStrobe;
  logic [PTR_W-1:0] wrAddr;
  logic [7:0]       wrData;
  logic             busy;

  modport master (
    output scl,
    output locAddr,
    input  locData,
    input  wrStrobe,
    input  wrAddr,
    input  wrData,
    input  busy
  );

  modport slave (
    input  scl,
    input  locAddr,
    output locData,
    output wrStrobe,
    output wrAddr,
    output wrData,
    output busy
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target with a 16 x 8-bit register file, an auto-incrementing register
// pointer, a registered local read port and a write-commit strobe.
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         REG_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  i2c_slave_regs_if.slave bus,
  inout  wire             sda
);
  localparam int PTR_W = $clog2(REG_DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_d1_q;
  logic sda_s1_q, sda_s2_q, sda_d1_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       shift_in;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       loc_data_q, loc_data_d;
  logic             reg_we;
  logic [7:0]       regs_q [REG_DEPTH];

  // Bring both bus lines into the clk domain; the third stage gives edge history.
  // Lines reset to the idle-high level so reset never fakes a START/STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d1_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d1_q <= 1'b1;
    end else begin
      scl_s1_q <= bus.scl;
      scl_s2_q <= scl_s1_q;
      scl_d1_q <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_d1_q <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_d1_q;
  assign scl_fall  = ~scl_s2_q & scl_d1_q;
  assign start_det = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;
  assign shift_in  = {shift_q[6:0], sda_s2_q};
  assign ptr_inc   = ptr_q + PTR_W'(1);

  // Protocol FSM: bits shift in on SCL rise, own SDA changes only on SCL fall.
  // In ACK states sda_oe_q doubles as the phase flag: first fall drives, second releases.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    loc_data_d  = regs_q[bus.locAddr];

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (shift_in[7:1] == DEV_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (shift_q[0]) begin
              state_d  = ST_RD_DATA;
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = ST_REG;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_REG: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ptr_d     = shift_in[PTR_W-1:0];
              state_d   = ST_REG_ACK;
            end
          end
        end
        ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d   = 4'd0;
              reg_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = shift_in;
              ptr_d       = ptr_inc;
              state_d     = ST_WR_ACK;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
              state_d = ST_RD_DATA;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers; async reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      loc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      loc_data_q  <= loc_data_d;
    end
  end

  // Register file, written once per committed bus data byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[ptr_q] <= shift_in;
    end
  end

  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.busy     = busy_q;
  assign bus.wrStrobe = wr_strobe_q;
  assign bus.wrAddr   = wr_addr_q;
  assign bus.wrData   = wr_data_q;
  assign bus.locData  = loc_data_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master, a write-commit scoreboard
// and a small register/pointer model supply every expected value.
module tb_i2c_slave_regs;
  localparam int Q = 100;

  logic clk = 1'b0;
  logic rst;
  logic m_sda_low;
  wire  sda;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  model [16];
  logic [3:0]  model_ptr;

  logic watch_on = 1'b0;
  logic saw_low;
  logic saw_busy;

  i2c_slave_regs_if bus ();

  i2c_slave_regs #(.DEV_ADDR(7'h50), .REG_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sda (sda)
  );

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  // Every wrStrobe sample must match the next queued commit; extra cycles count as errors.
  always @(negedge clk) begin
    if (!rst && bus.wrStrobe === 1'b1) begin
      logic [11:0] exp;
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL wr_strobe_unexpected: got addr=%0d data=%h, required no commit", bus.wrAddr, bus.wrData);
      end else begin
        exp = exp_wr_q.pop_front();
        if ({bus.wrAddr, bus.wrData} !== exp) begin
          errors++;
          $display("[TB] FAIL wr_commit: got addr=%0d data=%h, required addr=%0d data=%h", bus.wrAddr, bus.wrData, exp[11:8], exp[7:0]);
        end
      end
    end
  end

  // Watches for the target pulling SDA low or raising busy while armed.
  always @(negedge clk) begin
    if (watch_on) begin
      if (sda === 1'b0 && !m_sda_low) saw_low = 1'b1;
      if (bus.busy !== 1'b0) saw_busy = 1'b1;
    end
  end

  task automatic i2c_start();
    bus.scl = 1'b0; #Q;
    m_sda_low = 1'b0; #Q;
    bus.scl = 1'b1; #Q;
    m_sda_low = 1'b1; #Q;
    bus.scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    bus.scl = 1'b1; #Q;
    m_sda_low = 1'b0; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #Q;
    bus.scl = 1'b1; #(2*Q);
    bus.scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    bus.scl = 1'b1; #Q;
    b = (sda === 1'b0) ? 1'b0 : 1'b1; #Q;
    bus.scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  task automatic test_reset();
    $display("[TB] reset state");
    rst = 1'b1; m_sda_low = 1'b0; bus.scl = 1'b1; bus.locAddr = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model_ptr = 4'd0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b, required 1 (released)", sda); end
    checks++;
    if ({bus.busy, bus.wrStrobe, bus.wrAddr, bus.wrData, bus.locData} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b strobe=%b addr=%h data=%h loc=%h, required all 0",
               bus.busy, bus.wrStrobe, bus.wrAddr, bus.wrData, bus.locData);
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    $display("[TB] write 0x5A, 0xC3 from register 3");
    exp_wr_q.push_back({4'd3, 8'h5A});
    exp_wr_q.push_back({4'd4, 8'hC3});
    i2c_start();
    send_byte(8'hA0, a0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_high: got %b, required 1", bus.busy); end
    send_byte(8'h03, a1);
    send_byte(8'h5A, a2);
    send_byte(8'hC3, a3);
    i2c_stop();
    model[3] = 8'h5A; model[4] = 8'hC3; model_ptr = 4'd5;
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("[TB] FAIL write_acks: got %b, required 1111", {a0, a1, a2, a3}); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_low: got %b, required 0", bus.busy); end
    @(negedge clk) bus.locAddr = 4'd4;
    @(negedge clk);
    checks++;
    if (bus.locData !== model[4]) begin errors++; $display("[TB] FAIL write_locdata: got %h, required %h", bus.locData, model[4]); end
  endtask

  task automatic test_read_rep_start();
    logic a0, a1, a2;
    logic [7:0] d0, d1, e;
    $display("[TB] read two bytes after repeated START");
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    model_ptr = 4'd3;
    i2c_start();
    send_byte(8'hA1, a2);
    exp_rd_q.push_back(model[model_ptr]);
    recv_byte(1'b1, d0);
    model_ptr = model_ptr + 4'd1;
    exp_rd_q.push_back(model[model_ptr]);
    recv_byte(1'b0, d1);
    repeat (6) @(negedge clk);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("[TB] FAIL read_acks: got %b, required 111", {a0, a1, a2}); end
    e = exp_rd_q.pop_front();
    checks++;
    if (d0 !== e) begin errors++; $display("[TB] FAIL read_byte0: got %h, required %h", d0, e); end
    e = exp_rd_q.pop_front();
    checks++;
    if (d1 !== e) begin errors++; $display("[TB] FAIL read_byte1: got %h, required %h", d1, e); end
    checks++;
    if (sda !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL read_after_nack: got sda=%b busy=%b, required sda=1 busy=0", sda, bus.busy);
    end
    i2c_stop();
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1, a2;
    $display("[TB] foreign address 0xA2");
    saw_low = 1'b0; saw_busy = 1'b0; watch_on = 1'b1;
    i2c_start();
    send_byte(8'hA2, a0);
    send_byte(8'h00, a1);
    send_byte(8'hFF, a2);
    i2c_stop();
    watch_on = 1'b0;
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin errors++; $display("[TB] FAIL mismatch_acks: got %b, required 000", {a0, a1, a2}); end
    checks++;
    if (saw_low !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_sda: got driven low, required never driven"); end
    checks++;
    if (saw_busy !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_busy: got busy seen high, required 0"); end
    @(negedge clk) bus.locAddr = 4'd0;
    @(negedge clk);
    checks++;
    if (bus.locData !== model[0]) begin errors++; $display("[TB] FAIL mismatch_reg0: got %h, required %h", bus.locData, model[0]); end
  endtask

  task automatic test_pointer_wrap();
    logic a0, a1, a2, a3;
    $display("[TB] pointer wrap from register 15");
    exp_wr_q.push_back({4'd15, 8'h11});
    exp_wr_q.push_back({4'd0, 8'h22});
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h0F, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    i2c_stop();
    model[15] = 8'h11; model[0] = 8'h22; model_ptr = 4'd1;
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("[TB] FAIL wrap_acks: got %b, required 1111", {a0, a1, a2, a3}); end
    for (int i = 0; i < 16; i += 15) begin
      @(negedge clk) bus.locAddr = 4'(i);
      @(negedge clk);
      checks++;
      if (bus.locData !== model[i]) begin errors++; $display("[TB] FAIL wrap_reg%0d: got %h, required %h", i, bus.locData, model[i]); end
    end
  endtask

  task automatic test_abort_and_reset();
    logic a0, a1, a2, a3;
    $display("[TB] STOP mid-byte, then reset mid-read");
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h05, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    model_ptr = 4'd5;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, required 0", bus.busy); end
    @(negedge clk) bus.locAddr = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.locData !== model[5]) begin errors++; $display("[TB] FAIL abort_reg5: got %h, required %h", bus.locData, model[5]); end

    i2c_start();
    send_byte(8'hA0, a2);
    send_byte(8'h03, a3);
    i2c_start();
    send_byte(8'hA1, a0);
    repeat (2) @(negedge clk);
    checks++;
    if (sda !== model[3][7]) begin errors++; $display("[TB] FAIL read_first_bit: got %b, required %b", sda, model[3][7]); end
    rst = 1'b1;
    #1;
    checks++;
    if (sda !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_sda: got %b, required 1 (released)", sda); end
    checks++;
    if ({bus.busy, bus.wrStrobe, bus.wrAddr, bus.wrData, bus.locData} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got busy=%b strobe=%b addr=%h data=%h loc=%h, required all 0",
               bus.busy, bus.wrStrobe, bus.wrAddr, bus.wrData, bus.locData);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model_ptr = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_pointer_persist();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d, e;
    $display("[TB] write after reset, then pointer persistence");
    exp_wr_q.push_back({4'd7, 8'h9E});
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h07, a1);
    send_byte(8'h9E, a2);
    i2c_stop();
    model[7] = 8'h9E; model_ptr = 4'd8;
    i2c_start();
    send_byte(8'hA0, a3);
    send_byte(8'h07, a4);
    i2c_stop();
    model_ptr = 4'd7;
    i2c_start();
    send_byte(8'hA1, a5);
    exp_rd_q.push_back(model[model_ptr]);
    recv_byte(1'b0, d);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3, a4, a5} !== 6'b111111) begin
      errors++; $display("[TB] FAIL persist_acks: got %b, required 111111", {a0, a1, a2, a3, a4, a5});
    end
    e = exp_rd_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("[TB] FAIL persist_read: got %h, required %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_rep_start();
    test_addr_mismatch();
    test_pointer_wrap();
    test_abort_and_reset();
    test_pointer_persist();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("[TB] FAIL missing_commits: got %0d pending, required 0", exp_wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
